// File: rtl/tick_scheduler.sv
// Shared timebase: one free-running prescaler produces baseTick, and NUM_CH programmable
// channels divide it into one-cycle enable pulses. Config is single-entry, applied on a baseTick.
module tick_scheduler #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CH_W     = 2,
   parameter int unsigned PRESCALE = 100000,
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                clockIn,
   input  logic                resetN,
   input  logic                cfgValid,
   output logic                cfgReady,
   input  logic [CH_W-1:0]     cfgChannel,
   input  logic [PERIOD_W-1:0] cfgPeriod,
   output logic                baseTick,
   output logic [NUM_CH-1:0]   tickOut,
   output logic [NUM_CH-1:0]   activeMask
);

   localparam int unsigned    PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

   logic [PsW-1:0]                   ps_cnt_q, ps_cnt_d;
   logic                             base_tick_q, base_tick_d;
   logic                             pend_vld_q, pend_vld_d;
   logic [CH_W-1:0]                  pend_ch_q, pend_ch_d;
   logic [PERIOD_W-1:0]              pend_per_q, pend_per_d;
   logic [NUM_CH-1:0][PERIOD_W-1:0] period_q, period_d;
   logic [NUM_CH-1:0][PERIOD_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]                tick_q, tick_d;
   logic [NUM_CH-1:0]                active_q, active_d;
   logic                             cfg_xfer;
   logic                             cfg_apply;

   always_comb begin
      ps_cnt_d    = (ps_cnt_q == PsLast) ? '0 : ps_cnt_q + PsW'(1);
      base_tick_d = (ps_cnt_q == PsLast);
   end

   // Pending is only set on the edge that ends the transfer cycle, so a baseTick coincident
   // with the transfer is never used; the apply always lands on a later baseTick.
   assign cfg_xfer  = cfgValid && !pend_vld_q;
   assign cfg_apply = pend_vld_q && base_tick_q;

   always_comb begin
      pend_vld_d = pend_vld_q;
      pend_ch_d  = pend_ch_q;
      pend_per_d = pend_per_q;
      if (cfg_apply) begin
         pend_vld_d = 1'b0;
      end else if (cfg_xfer) begin
         pend_vld_d = 1'b1;
         pend_ch_d  = cfgChannel;
         pend_per_d = cfgPeriod;
      end
   end

   // Out-of-range channel indices match no channel, so they drain the pending slot silently.
   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      tick_d   = '0;
      active_d = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (cfg_apply && (pend_ch_q == CH_W'(ch))) begin
            period_d[ch] = pend_per_q;
            cnt_d[ch]    = '0;
         end else if (base_tick_q && (period_q[ch] != '0)) begin
            if (cnt_q[ch] == period_q[ch] - PERIOD_W'(1)) begin
               cnt_d[ch]  = '0;
               tick_d[ch] = 1'b1;
            end else begin
               cnt_d[ch] = cnt_q[ch] + PERIOD_W'(1);
            end
         end
         active_d[ch] = (period_d[ch] != '0);
      end
   end

   always_ff @(posedge clockIn or negedge resetN) begin
      if (!resetN) begin
         ps_cnt_q    <= '0;
         base_tick_q <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_ch_q   <= '0;
         pend_per_q  <= '0;
         period_q    <= '0;
         cnt_q       <= '0;
         tick_q      <= '0;
         active_q    <= '0;
      end else begin
         ps_cnt_q    <= ps_cnt_d;
         base_tick_q <= base_tick_d;
         pend_vld_q  <= pend_vld_d;
         pend_ch_q   <= pend_ch_d;
         pend_per_q  <= pend_per_d;
         period_q    <= period_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         active_q    <= active_d;
      end
   end

   assign cfgReady   = !pend_vld_q;
   assign baseTick   = base_tick_q;
   assign tickOut    = tick_q;
   assign activeMask = active_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler at PRESCALE=4: expected tick pulses are queued with their cycle
// numbers as config is driven; a negedge monitor matches every pulse against the queue.
module tb_tick_scheduler;

   localparam int NUM_CH   = 4;
   localparam int CH_W     = 2;
   localparam int PRESCALE = 4;
   localparam int PERIOD_W = 16;

   logic                clockIn = 1'b0;
   logic                resetN = 1'b0;
   logic                cfgValid = 1'b0;
   logic [CH_W-1:0]     cfgChannel = '0;
   logic [PERIOD_W-1:0] cfgPeriod = '0;
   logic                cfgReady;
   logic                baseTick;
   logic [NUM_CH-1:0]   tickOut;
   logic [NUM_CH-1:0]   activeMask;

   int checks = 0;
   int failures = 0;
   int cyc;
   int mon_idx;

   typedef struct {
      int cyc;
      int ch;
   } ev_t;
   ev_t exp_q[$];

   tick_scheduler #(
      .NUM_CH  (NUM_CH),
      .CH_W    (CH_W),
      .PRESCALE(PRESCALE),
      .PERIOD_W(PERIOD_W)
   ) dut (
      .clockIn   (clockIn),
      .resetN    (resetN),
      .cfgValid  (cfgValid),
      .cfgReady  (cfgReady),
      .cfgChannel(cfgChannel),
      .cfgPeriod (cfgPeriod),
      .baseTick  (baseTick),
      .tickOut   (tickOut),
      .activeMask(activeMask)
   );

   always #5 clockIn = ~clockIn;

   // Cycle k is the interval following the k-th rising edge after reset release.
   always @(posedge clockIn or negedge resetN) begin
      if (!resetN) cyc <= 0;
      else cyc <= cyc + 1;
   end

   always @(negedge clockIn) begin
      if (resetN) begin
         for (int b = 0; b < NUM_CH; b++) begin
            if (tickOut[b]) begin
               mon_idx = -1;
               for (int i = 0; i < exp_q.size(); i++) begin
                  if (mon_idx < 0 && exp_q[i].cyc == cyc && exp_q[i].ch == b) mon_idx = i;
               end
               checks++;
               if (mon_idx < 0) begin
                  failures++;
                  $display("FAIL tick_unexpected: tickOut[%0d]=1 at cycle %0d, required 0", b, cyc);
               end else begin
                  exp_q.delete(mon_idx);
               end
            end
         end
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
               checks++;
               failures++;
               $display("FAIL tick_missed: tickOut[%0d]=0 at cycle %0d, required 1",
                        exp_q[i].ch, exp_q[i].cyc);
               exp_q.delete(i);
            end
         end
      end
   end

   task automatic wait_cycle();
      @(posedge clockIn);
      #1;
   endtask

   task automatic goto(input int k);
      while (cyc < k) wait_cycle();
   endtask

   task automatic push_ev(input int c, input int ch);
      ev_t e;
      e.cyc = c;
      e.ch  = ch;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      resetN     = 1'b0;
      cfgValid   = 1'b0;
      cfgChannel = '0;
      cfgPeriod  = '0;
      repeat (3) @(posedge clockIn);
      exp_q.delete();
      @(negedge clockIn);
      resetN = 1'b1;
   endtask

   task automatic test_reset();
      logic exp_bt;
      resetN = 1'b0;
      repeat (3) @(posedge clockIn);
      #1;
      checks++;
      if (baseTick !== 1'b0 || cfgReady !== 1'b1 || activeMask !== 4'b0 || tickOut !== 4'b0) begin
         failures++;
         $display("FAIL reset_hold: bt=%b rdy=%b act=%b tick=%b, required 0 1 0000 0000",
                  baseTick, cfgReady, activeMask, tickOut);
      end
      @(negedge clockIn);
      resetN = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         goto(k);
         exp_bt = (k % PRESCALE == 0);
         checks++;
         if (baseTick !== exp_bt) begin
            failures++;
            $display("FAIL reset_baseTick cycle %0d: got %b, required %b", k, baseTick, exp_bt);
         end
         checks++;
         if (activeMask !== 4'b0000 || cfgReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: act=%b rdy=%b, required 0000 1",
                     k, activeMask, cfgReady);
         end
      end
   endtask

   task automatic test_basic();
      do_reset();
      goto(1);
      cfgValid = 1'b1; cfgChannel = 2'd1; cfgPeriod = 16'd3;
      push_ev(17, 1); push_ev(29, 1); push_ev(41, 1);
      goto(2);
      cfgValid = 1'b0;
      checks++;
      if (cfgReady !== 1'b0) begin
         failures++; $display("FAIL basic_ready_c2: got %b, required 0", cfgReady);
      end
      goto(4);
      checks++;
      if (cfgReady !== 1'b0 || activeMask !== 4'b0000) begin
         failures++;
         $display("FAIL basic_c4: rdy=%b act=%b, required 0 0000", cfgReady, activeMask);
      end
      goto(5);
      checks++;
      if (cfgReady !== 1'b1 || activeMask !== 4'b0010) begin
         failures++;
         $display("FAIL basic_c5: rdy=%b act=%b, required 1 0010", cfgReady, activeMask);
      end
      goto(45);
      @(negedge clockIn); #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL basic_pending_ticks: got %0d, required 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      goto(1);
      cfgValid = 1'b1; cfgChannel = 2'd0; cfgPeriod = 16'd1;
      for (int t = 9; t <= 41; t += 4) push_ev(t, 0);
      goto(2);
      cfgChannel = 2'd2; cfgPeriod = 16'd2;
      push_ev(17, 2); push_ev(25, 2); push_ev(33, 2); push_ev(41, 2);
      checks++;
      if (cfgReady !== 1'b0) begin
         failures++; $display("FAIL b2b_ready_c2: got %b, required 0", cfgReady);
      end
      goto(4);
      checks++;
      if (cfgReady !== 1'b0) begin
         failures++; $display("FAIL b2b_ready_c4: got %b, required 0", cfgReady);
      end
      goto(5);
      checks++;
      if (cfgReady !== 1'b1 || activeMask !== 4'b0001) begin
         failures++;
         $display("FAIL b2b_c5: rdy=%b act=%b, required 1 0001", cfgReady, activeMask);
      end
      goto(6);
      cfgValid = 1'b0;
      checks++;
      if (cfgReady !== 1'b0) begin
         failures++; $display("FAIL b2b_second_accept: rdy=%b, required 0", cfgReady);
      end
      goto(8);
      checks++;
      if (cfgReady !== 1'b0 || activeMask !== 4'b0001) begin
         failures++;
         $display("FAIL b2b_c8: rdy=%b act=%b, required 0 0001", cfgReady, activeMask);
      end
      goto(9);
      checks++;
      if (cfgReady !== 1'b1 || activeMask !== 4'b0101) begin
         failures++;
         $display("FAIL b2b_c9: rdy=%b act=%b, required 1 0101", cfgReady, activeMask);
      end
      goto(44);
      @(negedge clockIn); #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL b2b_pending_ticks: got %0d, required 0", exp_q.size());
      end
   endtask

   task automatic test_disable();
      do_reset();
      goto(1);
      cfgValid = 1'b1; cfgChannel = 2'd1; cfgPeriod = 16'd3;
      push_ev(17, 1); push_ev(29, 1);
      goto(2);
      cfgValid = 1'b0;
      goto(37);
      cfgValid = 1'b1; cfgChannel = 2'd1; cfgPeriod = 16'd0;
      goto(38);
      cfgValid = 1'b0;
      checks++;
      if (cfgReady !== 1'b0) begin
         failures++; $display("FAIL disable_ready_c38: got %b, required 0", cfgReady);
      end
      goto(40);
      checks++;
      if (activeMask !== 4'b0010 || baseTick !== 1'b1) begin
         failures++;
         $display("FAIL disable_c40: act=%b bt=%b, required 0010 1", activeMask, baseTick);
      end
      goto(41);
      checks++;
      if (activeMask !== 4'b0000 || cfgReady !== 1'b1) begin
         failures++;
         $display("FAIL disable_c41: act=%b rdy=%b, required 0000 1", activeMask, cfgReady);
      end
      goto(60);
      @(negedge clockIn); #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL disable_pending_ticks: got %0d, required 0", exp_q.size());
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      goto(4);
      checks++;
      if (baseTick !== 1'b1) begin
         failures++; $display("FAIL simul_bt_c4: got %b, required 1", baseTick);
      end
      cfgValid = 1'b1; cfgChannel = 2'd3; cfgPeriod = 16'd1;
      push_ev(13, 3); push_ev(17, 3); push_ev(21, 3);
      goto(5);
      cfgValid = 1'b0;
      checks++;
      if (cfgReady !== 1'b0 || activeMask !== 4'b0000) begin
         failures++;
         $display("FAIL simul_c5: rdy=%b act=%b, required 0 0000", cfgReady, activeMask);
      end
      goto(8);
      checks++;
      if (cfgReady !== 1'b0 || activeMask !== 4'b0000) begin
         failures++;
         $display("FAIL simul_c8: rdy=%b act=%b, required 0 0000", cfgReady, activeMask);
      end
      goto(9);
      checks++;
      if (cfgReady !== 1'b1 || activeMask !== 4'b1000) begin
         failures++;
         $display("FAIL simul_c9: rdy=%b act=%b, required 1 1000", cfgReady, activeMask);
      end
      goto(22);
      @(negedge clockIn); #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL simul_pending_ticks: got %0d, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_pending();
      do_reset();
      goto(1);
      cfgValid = 1'b1; cfgChannel = 2'd3; cfgPeriod = 16'd5;
      goto(2);
      cfgValid = 1'b0;
      checks++;
      if (cfgReady !== 1'b0) begin
         failures++; $display("FAIL rstpend_ready_c2: got %b, required 0", cfgReady);
      end
      goto(3);
      resetN = 1'b0;
      #1;
      checks++;
      if (cfgReady !== 1'b1 || activeMask !== 4'b0000 || baseTick !== 1'b0) begin
         failures++;
         $display("FAIL rstpend_async: rdy=%b act=%b bt=%b, required 1 0000 0",
                  cfgReady, activeMask, baseTick);
      end
      do_reset();
      for (int k = 5; k <= 9; k += 4) begin
         goto(k);
         checks++;
         if (cfgReady !== 1'b1 || activeMask !== 4'b0000) begin
            failures++;
            $display("FAIL rstpend_c%0d: rdy=%b act=%b, required 1 0000", k, cfgReady, activeMask);
         end
      end
      goto(40);
      @(negedge clockIn); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_disable();
      test_simultaneous();
      test_reset_pending();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: run still active at time 50000, required completion earlier");
      $fatal(1);
   end

endmodule
